// File: rtl/mlp_stream_loader_if.sv
// Host-side byte streams of the MLP loader: command bytes in (s_*) and
// captured result bytes out (m_*), both valid/ready.
interface mlp_stream_loader_if;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;

    // slave: the loader side; master: the host side
    modport slave (
        input  s_data, s_valid, m_ready,
        output s_ready, m_data, m_valid
    );
    modport master (
        output s_data, s_valid, m_ready,
        input  s_ready, m_data, m_valid
    );
endinterface

// File: rtl/mlp_stream_loader.sv
// Command-packet parser in front of the MLP core: loads inputs/weights/biases,
// configures and runs the core, and buffers its output bytes for the host.
module mlp_stream_loader #(
    parameter int OUT_FIFO_DEPTH = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    mlp_stream_loader_if.slave      host,
    output logic [15:0]             input_addr,
    output logic [7:0]              input_data,
    output logic                    input_we,
    output logic [15:0]             weight_addr,
    output logic [7:0]              weight_data,
    output logic                    weight_we,
    output logic [15:0]             bias_addr,
    output logic [7:0]              bias_data,
    output logic                    bias_we,
    output logic [15:0]             num_inputs,
    output logic [15:0]             num_outputs,
    output logic                    start,
    input  logic                    done,
    input  logic [7:0]              core_out_data,
    input  logic                    core_out_valid,
    output logic                    busy,
    output logic                    err_opcode,
    output logic                    err_overflow
);
    localparam int AW = $clog2(OUT_FIFO_DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(OUT_FIFO_DEPTH);
    localparam logic [AW:0] ONE_CNT  = (AW+1)'(1);

    typedef enum logic [2:0] {
        IDLE, HDR, PAYLOAD, RUN_START, RUN_WAIT, RUN_RELEASE
    } state_t;

    state_t      state_reg;
    logic [2:0]  op_reg;
    logic [1:0]  hdr_cnt_reg;
    logic [15:0] field_a_reg;
    logic [7:0]  field_b_lo_reg;
    logic [15:0] addr_ptr_reg;
    logic [15:0] remain_reg;
    logic        s_ready_reg;
    logic        busy_reg;
    logic        s_fire;
    logic [15:0] field_b;

    assign s_fire       = host.s_valid && s_ready_reg;
    assign field_b      = {host.s_data, field_b_lo_reg};
    assign host.s_ready = s_ready_reg;
    assign busy         = busy_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            op_reg         <= '0;
            hdr_cnt_reg    <= '0;
            field_a_reg    <= '0;
            field_b_lo_reg <= '0;
            addr_ptr_reg   <= '0;
            remain_reg     <= '0;
            s_ready_reg    <= 1'b0;
            busy_reg       <= 1'b0;
            input_addr     <= '0;
            input_data     <= '0;
            input_we       <= 1'b0;
            weight_addr    <= '0;
            weight_data    <= '0;
            weight_we      <= 1'b0;
            bias_addr      <= '0;
            bias_data      <= '0;
            bias_we        <= 1'b0;
            num_inputs     <= '0;
            num_outputs    <= '0;
            start          <= 1'b0;
            err_opcode     <= 1'b0;
        end else begin
            input_we  <= 1'b0;
            weight_we <= 1'b0;
            bias_we   <= 1'b0;
            case (state_reg)
                IDLE: begin
                    s_ready_reg <= 1'b1;
                    busy_reg    <= 1'b0;
                    if (s_fire) begin
                        case (host.s_data)
                            8'h01, 8'h02, 8'h03, 8'h04: begin
                                op_reg      <= host.s_data[2:0];
                                hdr_cnt_reg <= '0;
                                state_reg   <= HDR;
                                busy_reg    <= 1'b1;
                            end
                            8'h05: begin
                                start       <= 1'b1;
                                s_ready_reg <= 1'b0;
                                busy_reg    <= 1'b1;
                                state_reg   <= RUN_START;
                            end
                            default: err_opcode <= 1'b1;
                        endcase
                    end
                end
                HDR: begin
                    if (s_fire) begin
                        hdr_cnt_reg <= hdr_cnt_reg + 2'd1;
                        case (hdr_cnt_reg)
                            2'd0: field_a_reg[7:0]  <= host.s_data;
                            2'd1: field_a_reg[15:8] <= host.s_data;
                            2'd2: field_b_lo_reg    <= host.s_data;
                            default: begin
                                if (op_reg == 3'd4) begin
                                    num_inputs  <= field_a_reg;
                                    num_outputs <= field_b;
                                    state_reg   <= IDLE;
                                    busy_reg    <= 1'b0;
                                end else if (field_b == 16'd0) begin
                                    state_reg <= IDLE;
                                    busy_reg  <= 1'b0;
                                end else begin
                                    addr_ptr_reg <= field_a_reg;
                                    remain_reg   <= field_b;
                                    state_reg    <= PAYLOAD;
                                end
                            end
                        endcase
                    end
                end
                PAYLOAD: begin
                    if (s_fire) begin
                        case (op_reg)
                            3'd1: begin
                                input_we   <= 1'b1;
                                input_addr <= addr_ptr_reg;
                                input_data <= host.s_data;
                            end
                            3'd2: begin
                                weight_we   <= 1'b1;
                                weight_addr <= addr_ptr_reg;
                                weight_data <= host.s_data;
                            end
                            default: begin
                                bias_we   <= 1'b1;
                                bias_addr <= addr_ptr_reg;
                                bias_data <= host.s_data;
                            end
                        endcase
                        // 16-bit address naturally wraps 0xFFFF -> 0x0000
                        addr_ptr_reg <= addr_ptr_reg + 16'd1;
                        remain_reg   <= remain_reg - 16'd1;
                        if (remain_reg == 16'd1) begin
                            state_reg <= IDLE;
                            busy_reg  <= 1'b0;
                        end
                    end
                end
                RUN_START: state_reg <= RUN_WAIT;
                RUN_WAIT: begin
                    if (done) begin
                        start     <= 1'b0;
                        state_reg <= RUN_RELEASE;
                    end
                end
                RUN_RELEASE: begin
                    if (!done) begin
                        state_reg   <= IDLE;
                        busy_reg    <= 1'b0;
                        s_ready_reg <= 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Output FIFO with a registered head entry (first-word-fall-through)
    logic [7:0]  fifo_mem [OUT_FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW-1:0] rd_ptr_next;
    logic [AW:0]   count_reg;
    logic [7:0]    head_reg;
    logic          fifo_empty;
    logic          fifo_full;
    logic          pop;
    logic          push;

    assign fifo_empty   = (count_reg == '0);
    assign fifo_full    = (count_reg == FULL_CNT);
    assign pop          = !fifo_empty && host.m_ready;
    assign push         = core_out_valid && (!fifo_full || pop);
    assign rd_ptr_next  = rd_ptr_reg + 1'b1;
    assign host.m_valid = !fifo_empty;
    assign host.m_data  = head_reg;

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_reg] <= core_out_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            head_reg     <= '0;
            err_overflow <= 1'b0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_next;
            if (push && !pop)      count_reg <= count_reg + ONE_CNT;
            else if (pop && !push) count_reg <= count_reg - ONE_CNT;
            // Head comes straight from the core when the FIFO is (about to be) empty
            if (push && (fifo_empty || (pop && count_reg == ONE_CNT)))
                head_reg <= core_out_data;
            else if (pop && count_reg > ONE_CNT)
                head_reg <= fifo_mem[rd_ptr_next];
            if (core_out_valid && fifo_full && !pop)
                err_overflow <= 1'b1;
        end
    end
endmodule

// File: tb/tb_mlp_stream_loader.sv
// Directed bench for mlp_stream_loader: load-vector table plus hand sequences
// for config/run, FIFO full/overflow, bad opcode and mid-packet reset.
module tb_mlp_stream_loader;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mlp_stream_loader_if hif();

    logic [15:0] input_addr, weight_addr, bias_addr;
    logic [7:0]  input_data, weight_data, bias_data;
    logic        input_we, weight_we, bias_we;
    logic [15:0] num_inputs, num_outputs;
    logic        start, done, busy, err_opcode, err_overflow;
    logic [7:0]  core_out_data;
    logic        core_out_valid;

    mlp_stream_loader #(.OUT_FIFO_DEPTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .host(hif),
        .input_addr(input_addr), .input_data(input_data), .input_we(input_we),
        .weight_addr(weight_addr), .weight_data(weight_data), .weight_we(weight_we),
        .bias_addr(bias_addr), .bias_data(bias_data), .bias_we(bias_we),
        .num_inputs(num_inputs), .num_outputs(num_outputs),
        .start(start), .done(done),
        .core_out_data(core_out_data), .core_out_valid(core_out_valid),
        .busy(busy), .err_opcode(err_opcode), .err_overflow(err_overflow)
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          kind;
        logic [15:0] addr;
        logic [7:0]  data;
        int          cyc;
    } wr_t;
    wr_t wlog[$];

    function void log_wr(int kind, logic [15:0] a, logic [7:0] d);
        wr_t r;
        r.kind = kind; r.addr = a; r.data = d; r.cyc = cyc;
        wlog.push_back(r);
    endfunction

    always @(negedge clk) begin
        if (input_we)  log_wr(1, input_addr, input_data);
        if (weight_we) log_wr(2, weight_addr, weight_data);
        if (bias_we)   log_wr(3, bias_addr, bias_data);
    end

    function void check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s = 0x%0h", name, act);
        end
    endfunction

    task tick;
        @(posedge clk);
        #1;
    endtask

    logic [7:0] txq[$];

    // Streams txq back-to-back; returns #1 after the edge accepting the last byte
    task send_q;
        logic r;
        int guard;
        for (int i = 0; i < txq.size(); i++) begin
            hif.s_valid = 1'b1;
            hif.s_data  = txq[i];
            guard = 0;
            while (1) begin
                r = hif.s_ready;
                tick();
                if (r) break;
                guard++;
                if (guard > 50) begin
                    check("send_timeout", 32'd0, 32'd1);
                    hif.s_valid = 1'b0;
                    txq.delete();
                    return;
                end
            end
        end
        hif.s_valid = 1'b0;
        txq.delete();
    endtask

    typedef struct {
        logic [7:0]  op;
        logic [15:0] base;
        logic [15:0] len;
        logic [7:0]  pl[4];
        logic [15:0] ea[4];
    } vec_t;
    vec_t vt[4];

    initial begin
        vt[0].op = 8'h01; vt[0].base = 16'h0010; vt[0].len = 16'd3;
        vt[0].pl = '{8'hAA, 8'hBB, 8'hCC, 8'h00};
        vt[0].ea = '{16'h0010, 16'h0011, 16'h0012, 16'h0000};
        vt[1].op = 8'h02; vt[1].base = 16'hFFFE; vt[1].len = 16'd3;
        vt[1].pl = '{8'h01, 8'h02, 8'h03, 8'h00};
        vt[1].ea = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0000};
        vt[2].op = 8'h03; vt[2].base = 16'h0100; vt[2].len = 16'd2;
        vt[2].pl = '{8'h5A, 8'hA5, 8'h00, 8'h00};
        vt[2].ea = '{16'h0100, 16'h0101, 16'h0000, 16'h0000};
        vt[3].op = 8'h01; vt[3].base = 16'h0200; vt[3].len = 16'd0;
        vt[3].pl = '{8'h00, 8'h00, 8'h00, 8'h00};
        vt[3].ea = '{16'h0000, 16'h0000, 16'h0000, 16'h0000};

        hif.s_valid = 1'b0; hif.s_data = 8'h00; hif.m_ready = 1'b0;
        done = 1'b0; core_out_valid = 1'b0; core_out_data = 8'h00;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_input_we", input_we, 0);
        check("rst_weight_addr", weight_addr, 0);
        check("rst_num_outputs", num_outputs, 0);
        check("rst_start", start, 0);
        check("rst_m_valid", hif.m_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_err_opcode", err_opcode, 0);
        rst_n = 1'b1;
        tick(); tick();

        // Load-packet vector table
        for (int v = 0; v < 4; v++) begin
            wlog.delete();
            txq.push_back(vt[v].op);
            txq.push_back(vt[v].base[7:0]);
            txq.push_back(vt[v].base[15:8]);
            txq.push_back(vt[v].len[7:0]);
            txq.push_back(vt[v].len[15:8]);
            for (int k = 0; k < int'(vt[v].len); k++) txq.push_back(vt[v].pl[k]);
            send_q();
            tick(); tick();
            check($sformatf("v%0d_count", v), wlog.size(), vt[v].len);
            for (int k = 0; k < int'(vt[v].len) && k < wlog.size(); k++) begin
                check($sformatf("v%0d_kind%0d", v, k), wlog[k].kind, vt[v].op);
                check($sformatf("v%0d_addr%0d", v, k), wlog[k].addr, vt[v].ea[k]);
                check($sformatf("v%0d_data%0d", v, k), wlog[k].data, vt[v].pl[k]);
                if (k > 0)
                    check($sformatf("v%0d_b2b%0d", v, k), wlog[k].cyc - wlog[k-1].cyc, 1);
            end
            check($sformatf("v%0d_idle", v), {busy, hif.s_ready}, 2'b01);
        end

        // CONFIG then RUN
        txq = '{8'h04, 8'h40, 8'h00, 8'h0A, 8'h00};
        send_q();
        check("cfg_num_inputs", num_inputs, 16'd64);
        check("cfg_num_outputs", num_outputs, 16'd10);
        txq = '{8'h05};
        send_q();
        check("run_start_rise", start, 1);
        check("run_s_ready_low", hif.s_ready, 0);
        check("run_busy", busy, 1);
        repeat (4) tick();
        check("run_start_held", start, 1);
        check("run_s_ready_held", hif.s_ready, 0);
        done = 1'b1;
        tick();
        check("run_start_fall", start, 0);
        check("run_busy_release", busy, 1);
        tick();
        check("run_busy_done_high", busy, 1);
        done = 1'b0;
        tick();
        check("run_busy_clear", busy, 0);
        check("run_s_ready_back", hif.s_ready, 1);

        // FIFO: simultaneous push and pop while full
        for (int i = 0; i < 16; i++) begin
            core_out_valid = 1'b1; core_out_data = 8'(100 + i);
            tick();
        end
        core_out_data = 8'd116; hif.m_ready = 1'b1;
        tick();
        core_out_valid = 1'b0;
        check("full_pushpop_no_ovf", err_overflow, 0);
        for (int j = 0; j < 16; j++) begin
            check($sformatf("pp_valid%0d", j), hif.m_valid, 1);
            check($sformatf("pp_data%0d", j), hif.m_data, 8'(101 + j));
            tick();
        end
        check("pp_empty", hif.m_valid, 0);
        hif.m_ready = 1'b0;

        // FIFO overflow: 20 bytes into 16 entries
        for (int i = 0; i < 20; i++) begin
            core_out_valid = 1'b1; core_out_data = 8'(i);
            tick();
            if (i == 15) check("ovf_not_yet", err_overflow, 0);
        end
        core_out_valid = 1'b0;
        check("ovf_flag", err_overflow, 1);
        hif.m_ready = 1'b1;
        for (int j = 0; j < 16; j++) begin
            check($sformatf("drain_valid%0d", j), hif.m_valid, 1);
            check($sformatf("drain_data%0d", j), hif.m_data, 8'(j));
            tick();
        end
        check("drain_empty", hif.m_valid, 0);
        hif.m_ready = 1'b0;

        // Unknown opcode followed by a single-byte bias load
        check("opc_clear", err_opcode, 0);
        wlog.delete();
        txq = '{8'h07, 8'h03, 8'h00, 8'h00, 8'h01, 8'h00, 8'h55};
        send_q();
        tick(); tick();
        check("opc_flag", err_opcode, 1);
        check("opc_count", wlog.size(), 1);
        if (wlog.size() > 0) begin
            check("opc_kind", wlog[0].kind, 3);
            check("opc_addr", wlog[0].addr, 16'h0000);
            check("opc_data", wlog[0].data, 8'h55);
        end

        // Reset in the middle of a payload
        core_out_valid = 1'b1; core_out_data = 8'h77;
        tick();
        core_out_valid = 1'b0;
        txq = '{8'h01, 8'h00, 8'h03, 8'h04, 8'h00, 8'hE1, 8'hE2};
        send_q();
        rst_n = 1'b0;
        #1;
        wlog.delete();
        check("mid_rst_input_we", input_we, 0);
        check("mid_rst_input_addr", input_addr, 0);
        check("mid_rst_num_inputs", num_inputs, 0);
        check("mid_rst_err_opcode", err_opcode, 0);
        check("mid_rst_err_overflow", err_overflow, 0);
        check("mid_rst_m_valid", hif.m_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_s_ready", hif.s_ready, 0);
        tick(); tick();
        rst_n = 1'b1;
        tick(); tick();
        check("post_rst_no_wr", wlog.size(), 0);
        txq = '{8'h01, 8'h20, 8'h00, 8'h02, 8'h00, 8'h11, 8'h22};
        send_q();
        tick(); tick();
        check("post_rst_count", wlog.size(), 2);
        if (wlog.size() == 2) begin
            check("post_rst_addr0", wlog[0].addr, 16'h0020);
            check("post_rst_data0", wlog[0].data, 8'h11);
            check("post_rst_addr1", wlog[1].addr, 16'h0021);
            check("post_rst_data1", wlog[1].data, 8'h22);
            check("post_rst_kind", wlog[1].kind, 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
